// File: rtl/regfile_pkg.sv
// rtl/regfile_pkg.sv - shared register-file widths, zero-register address and grant encoding
package regfile_pkg;

    localparam int REG_WIDTH   = 32;
    localparam int RADDR_WIDTH = 5;

    localparam logic [RADDR_WIDTH-1:0] ZERO_REG = '0;

    typedef enum logic {
        GNT_A = 1'b0,
        GNT_B = 1'b1
    } grant_e;

endpackage

// File: rtl/rr_arbiter2.sv
// rtl/rr_arbiter2.sv - two-requester arbiter; round-robin when WB_ARB_ROUND_ROBIN_EN is defined, else A-priority
module rr_arbiter2
    import regfile_pkg::*;
(
`ifdef WB_ARB_ROUND_ROBIN_EN
    input  logic       clk,
    input  logic       rst,
`endif
    input  logic [1:0] req,
    output logic [1:0] gnt
);

`ifdef WB_ARB_ROUND_ROBIN_EN
    grant_e last_grant;

    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = (last_grant == GNT_B) ? 2'b01 : 2'b10;
        end
    end

    // every grant is a completed transfer, so any grant advances the pointer
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= GNT_B;
        end else if (|gnt) begin
            last_grant <= gnt[1] ? GNT_B : GNT_A;
        end
    end
`else
    assign gnt = req[0] ? 2'b01 : req;
`endif

endmodule

// File: rtl/regfile_wb_arbiter.sv
// rtl/regfile_wb_arbiter.sv - register-file write-port arbiter for ALU (A) and load (B) writebacks; option WB_ARB_ROUND_ROBIN_EN
module regfile_wb_arbiter
    import regfile_pkg::*;
#(
    parameter int REG_WIDTH   = regfile_pkg::REG_WIDTH,
    parameter int RADDR_WIDTH = regfile_pkg::RADDR_WIDTH,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   hold,
    input  logic                   a_valid,
    input  logic [RADDR_WIDTH-1:0] a_addr,
    input  logic [REG_WIDTH-1:0]   a_data,
    output logic                   a_ready,
    input  logic                   b_valid,
    input  logic [RADDR_WIDTH-1:0] b_addr,
    input  logic [REG_WIDTH-1:0]   b_data,
    output logic                   b_ready,
    output logic                   we,
    output logic [RADDR_WIDTH-1:0] rd_addr,
    output logic [REG_WIDTH-1:0]   rd_value,
    output logic [CNT_WIDTH-1:0]   conflicts
);

    localparam logic [RADDR_WIDTH-1:0] ZERO_ADDR = RADDR_WIDTH'(ZERO_REG);

    logic [1:0] req;
    logic [1:0] gnt;
    logic       conflict;

    // reset also gates requests so nothing is granted while rst is low
    assign req      = {b_valid, a_valid} & {2{~hold & rst}};
    assign conflict = a_valid & b_valid & ~hold;
    assign a_ready  = gnt[0];
    assign b_ready  = gnt[1];

    rr_arbiter2 u_arb (
`ifdef WB_ARB_ROUND_ROBIN_EN
        .clk (clk),
        .rst (rst),
`endif
        .req (req),
        .gnt (gnt)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            we        <= 1'b0;
            rd_addr   <= '0;
            rd_value  <= '0;
            conflicts <= '0;
        end else begin
            we <= 1'b0;
            if (a_ready && a_addr != ZERO_ADDR) begin
                we       <= 1'b1;
                rd_addr  <= a_addr;
                rd_value <= a_data;
            end else if (b_ready && b_addr != ZERO_ADDR) begin
                we       <= 1'b1;
                rd_addr  <= b_addr;
                rd_value <= b_data;
            end
            if (conflict && conflicts != '1) begin
                conflicts <= conflicts + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// tb/tb_regfile_wb_arbiter.sv - directed self-checking bench for regfile_wb_arbiter
module tb_regfile_wb_arbiter;

    logic        clk;
    logic        rst;
    logic        hold;
    logic        a_valid;
    logic [4:0]  a_addr;
    logic [31:0] a_data;
    logic        a_ready;
    logic        b_valid;
    logic [4:0]  b_addr;
    logic [31:0] b_data;
    logic        b_ready;
    logic        we;
    logic [4:0]  rd_addr;
    logic [31:0] rd_value;
    logic [15:0] conflicts;

    int total = 0;
    int bad   = 0;

`ifdef WB_ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    regfile_wb_arbiter dut (
        .clk       (clk),
        .rst       (rst),
        .hold      (hold),
        .a_valid   (a_valid),
        .a_addr    (a_addr),
        .a_data    (a_data),
        .a_ready   (a_ready),
        .b_valid   (b_valid),
        .b_addr    (b_addr),
        .b_data    (b_data),
        .b_ready   (b_ready),
        .we        (we),
        .rd_addr   (rd_addr),
        .rd_value  (rd_value),
        .conflicts (conflicts)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic idle_inputs();
        hold = 1'b0; a_valid = 1'b0; a_addr = '0; a_data = '0;
        b_valid = 1'b0; b_addr = '0; b_data = '0;
    endtask

    task automatic do_reset();
        rst = 1'b0;
        idle_inputs();
        @(posedge clk); #1;
        rst = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        idle_inputs();
        a_valid = 1'b1; a_addr = 5'd3; a_data = 32'd77;
        @(posedge clk); #1;
        total++; if (we !== 1'b0) begin bad++; $display("FAIL reset_we got=%b exp=0", we); end
        total++; if (rd_addr !== 5'd0) begin bad++; $display("FAIL reset_rd_addr got=%0d exp=0", rd_addr); end
        total++; if (rd_value !== 32'd0) begin bad++; $display("FAIL reset_rd_value got=%h exp=0", rd_value); end
        total++; if (conflicts !== 16'd0) begin bad++; $display("FAIL reset_conflicts got=%0d exp=0", conflicts); end
        total++; if (a_ready !== 1'b0) begin bad++; $display("FAIL reset_a_ready got=%b exp=0", a_ready); end
        rst = 1'b1;
        #1;
        total++; if (a_ready !== 1'b1) begin bad++; $display("FAIL release_a_ready got=%b exp=1", a_ready); end
        @(posedge clk); #1;
        a_valid = 1'b0;
        total++; if (we !== 1'b1 || rd_addr !== 5'd3 || rd_value !== 32'd77) begin
            bad++; $display("FAIL release_first_write got=%b/%0d/%0d exp=1/3/77", we, rd_addr, rd_value);
        end
    endtask

    task automatic test_single();
        a_valid = 1'b1; a_addr = 5'd5; a_data = 32'hDEADBEEF;
        #1;
        total++; if (a_ready !== 1'b1 || b_ready !== 1'b0) begin
            bad++; $display("FAIL single_ready got=%b%b exp=10", a_ready, b_ready);
        end
        @(posedge clk); #1;
        a_valid = 1'b0;
        total++; if (we !== 1'b1 || rd_addr !== 5'd5 || rd_value !== 32'hDEADBEEF) begin
            bad++; $display("FAIL single_write got=%b/%0d/%h exp=1/5/deadbeef", we, rd_addr, rd_value);
        end
        @(posedge clk); #1;
        total++; if (we !== 1'b0 || rd_addr !== 5'd5) begin
            bad++; $display("FAIL single_we_drop got=%b/%0d exp=0/5", we, rd_addr);
        end
    endtask

    task automatic test_conflict();
        logic [4:0] exp_addr;
        logic [31:0] exp_data;
        do_reset();
        a_valid = 1'b1; a_addr = 5'd1; a_data = 32'h11;
        b_valid = 1'b1; b_addr = 5'd2; b_data = 32'h22;
        for (int i = 0; i < 4; i++) begin
            exp_addr = (RR && i[0]) ? 5'd2 : 5'd1;
            exp_data = (RR && i[0]) ? 32'h22 : 32'h11;
            #1;
            total++; if (a_ready !== (exp_addr == 5'd1) || b_ready !== (exp_addr == 5'd2)) begin
                bad++; $display("FAIL conflict_ready[%0d] got=%b%b exp_winner=%0d", i, a_ready, b_ready, exp_addr);
            end
            @(posedge clk); #1;
            total++; if (we !== 1'b1 || rd_addr !== exp_addr || rd_value !== exp_data) begin
                bad++; $display("FAIL conflict_write[%0d] got=%b/%0d/%h exp=1/%0d/%h", i, we, rd_addr, rd_value, exp_addr, exp_data);
            end
        end
        a_valid = 1'b0; b_valid = 1'b0;
        total++; if (conflicts !== 16'd4) begin bad++; $display("FAIL conflict_count got=%0d exp=4", conflicts); end
    endtask

    task automatic test_x0();
        logic [4:0]  prev_addr;
        logic [31:0] prev_data;
        prev_addr = RR ? 5'd2 : 5'd1;
        prev_data = RR ? 32'h22 : 32'h11;
        b_valid = 1'b1; b_addr = 5'd0; b_data = 32'hFFFFFFFF;
        #1;
        total++; if (b_ready !== 1'b1) begin bad++; $display("FAIL x0_b_ready got=%b exp=1", b_ready); end
        @(posedge clk); #1;
        b_valid = 1'b0;
        total++; if (we !== 1'b0 || rd_addr !== prev_addr || rd_value !== prev_data) begin
            bad++; $display("FAIL x0_discard got=%b/%0d/%h exp=0/%0d/%h", we, rd_addr, rd_value, prev_addr, prev_data);
        end
    endtask

    task automatic test_hold();
        hold = 1'b1;
        a_valid = 1'b1; a_addr = 5'd9;  a_data = 32'h99;
        b_valid = 1'b1; b_addr = 5'd10; b_data = 32'hAA;
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (a_ready !== 1'b0 || b_ready !== 1'b0) begin
                bad++; $display("FAIL hold_ready[%0d] got=%b%b exp=00", i, a_ready, b_ready);
            end
            @(posedge clk); #1;
            total++; if (we !== 1'b0 || conflicts !== 16'd4) begin
                bad++; $display("FAIL hold_out[%0d] got=%b/%0d exp=0/4", i, we, conflicts);
            end
        end
        idle_inputs();
    endtask

    task automatic test_back_to_back();
        a_valid = 1'b1; a_addr = 5'd7; a_data = 32'd1;
        @(posedge clk); #1;
        total++; if (we !== 1'b1 || rd_addr !== 5'd7 || rd_value !== 32'd1) begin
            bad++; $display("FAIL b2b_first got=%b/%0d/%0d exp=1/7/1", we, rd_addr, rd_value);
        end
        a_data = 32'd2;
        @(posedge clk); #1;
        a_valid = 1'b0;
        total++; if (we !== 1'b1 || rd_addr !== 5'd7 || rd_value !== 32'd2) begin
            bad++; $display("FAIL b2b_second got=%b/%0d/%0d exp=1/7/2", we, rd_addr, rd_value);
        end
        @(posedge clk); #1;
        total++; if (we !== 1'b0 || rd_value !== 32'd2) begin
            bad++; $display("FAIL b2b_end got=%b/%0d exp=0/2", we, rd_value);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        a_valid = 1'b1; a_addr = 5'd4; a_data = 32'h4;
        b_valid = 1'b1; b_addr = 5'd6; b_data = 32'h6;
        repeat (65534) @(posedge clk);
        #1;
        total++; if (conflicts !== 16'hFFFE) begin bad++; $display("FAIL sat_pre got=%h exp=fffe", conflicts); end
        repeat (3) @(posedge clk);
        #1;
        total++; if (conflicts !== 16'hFFFF) begin bad++; $display("FAIL sat_hold got=%h exp=ffff", conflicts); end
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_single();
        test_conflict();
        test_x0();
        test_hold();
        test_back_to_back();
        test_saturation();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
